// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// Covers FSM states, ALU operation classes, opcodes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BEQ,
        JAL
    } mc_state_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD,
        ALU_OP_SUB,
        ALU_OP_FUNCT
    } alu_op_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction fields to an ALU control code.
module alu_decoder
    import mc_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALUC_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALUC_ADD;
            ALU_OP_SUB: alu_control = ALUC_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // op[5] separates R-type sub from addi with a stray instr[30]
                    3'b000:  alu_control = (funct7b5 && op5) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  alu_control = ALUC_SLT;
                    3'b110:  alu_control = ALUC_OR;
                    3'b111:  alu_control = ALUC_AND;
                    default: alu_control = ALUC_ADD;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: 11-state Moore FSM driving write enables and mux selects,
// with branch resolution and immediate-format decode.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       instr_done
);

    mc_state_t  state;
    mc_state_t  next_state;
    alu_op_t    alu_op;
    logic       pc_update;
    logic       branch;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic       instr_done_s;
    logic [1:0] imm_src_s;
    logic [2:0] alu_control_s;

    always_ff @(posedge clk) begin
        if (reset)
            state <= FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state   = FETCH;
        alu_op       = ALU_OP_ADD;
        pc_update    = 1'b0;
        branch       = 1'b0;
        adr_src_s    = ADR_PC;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = RES_ALUOUT;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_RS2;
        instr_done_s = 1'b0;
        case (state)
            FETCH: begin
                next_state   = DECODE;
                ir_write_s   = 1'b1;
                alu_src_b_s  = SRCB_FOUR;
                result_src_s = RES_ALURESULT;
                pc_update    = 1'b1;
            end
            DECODE: begin
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTER;
                    OP_ITYPE:     next_state = EXECUTEI;
                    OP_JAL:       next_state = JAL;
                    OP_BEQ:       next_state = BEQ;
                    // unknown opcodes retire here without touching any state
                    default: begin
                        next_state   = FETCH;
                        instr_done_s = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                next_state  = (op == OP_LW) ? MEMREAD : MEMWRITE;
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
            end
            MEMREAD: begin
                next_state = MEMWB;
                adr_src_s  = ADR_RESULT;
            end
            MEMWB: begin
                result_src_s = RES_MEMDATA;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            MEMWRITE: begin
                adr_src_s    = ADR_RESULT;
                mem_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            EXECUTER: begin
                next_state  = ALUWB;
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_RS2;
                alu_op      = ALU_OP_FUNCT;
            end
            EXECUTEI: begin
                next_state  = ALUWB;
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
                alu_op      = ALU_OP_FUNCT;
            end
            ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            BEQ: begin
                alu_src_a_s  = SRCA_RS1;
                alu_src_b_s  = SRCB_RS2;
                alu_op       = ALU_OP_SUB;
                branch       = 1'b1;
                instr_done_s = 1'b1;
            end
            JAL: begin
                next_state  = ALUWB;
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_FOUR;
                pc_update   = 1'b1;
            end
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src_s = IMM_S;
            OP_BEQ:  imm_src_s = IMM_B;
            OP_JAL:  imm_src_s = IMM_J;
            default: imm_src_s = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control_s)
    );

    // funct3[0] inverts the zero test so one state serves both beq and bne
    assign pc_write    = !reset && (pc_update || (branch && (zero ^ funct3[0])));
    assign adr_src     = !reset && adr_src_s;
    assign mem_write   = !reset && mem_write_s;
    assign ir_write    = !reset && ir_write_s;
    assign reg_write   = !reset && reg_write_s;
    assign instr_done  = !reset && instr_done_s;
    assign result_src  = reset ? 2'b00  : result_src_s;
    assign alu_src_a   = reset ? 2'b00  : alu_src_a_s;
    assign alu_src_b   = reset ? 2'b00  : alu_src_b_s;
    assign imm_src     = reset ? 2'b00  : imm_src_s;
    assign alu_control = reset ? 3'b000 : alu_control_s;

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the RISC-V multicycle core: an 11-state Moore FSM plus a combinational ALU/immediate decoder. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the write enables and datapath mux selects, including the `pc_write` enable consumed by the program counter register. It takes opcode fields from the instruction register and `zero` from the ALU.

## Interface
Parameters: none.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `op` in 7: instr[6:0] from the instruction register.
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU result equals zero.
- `pc_write` out 1: PC register load enable.
- `adr_src` out 1: memory address select; 0 = PC, 1 = result.
- `mem_write` out 1: data memory write enable.
- `ir_write` out 1: instruction register load enable.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: result mux select; 00 = alu_out reg, 01 = mem data, 10 = ALU result.
- `alu_src_a` out 2: ALU A select; 00 = PC, 01 = old PC, 10 = rs1 data.
- `alu_src_b` out 2: ALU B select; 00 = rs2 data, 01 = imm, 10 = constant 4.
- `imm_src` out 2: immediate format; 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.

## Operation
- State transitions:
  - FETCH → DECODE.
  - DECODE, by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1101111 → JAL
    - 1100011 → BEQ
    - any other opcode → FETCH, with `instr_done`=1 (illegal opcode skipped; no writes).
  - MEMADR: `op`=0000011 → MEMREAD, otherwise → MEMWRITE.
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECUTER, EXECUTEI, JAL → ALUWB → FETCH.
  - BEQ → FETCH.
- Moore outputs per state. Unlisted outputs are 0 / 00.
  - FETCH: `ir_write`=1, `alu_src_b`=10, `result_src`=10, alu_op add, pc_update=1.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, alu_op add (branch target into alu_out).
  - MEMADR: `alu_src_a`=10, `alu_src_b`=01, add.
  - MEMREAD: `adr_src`=1.
  - MEMWB: `result_src`=01, `reg_write`=1.
  - MEMWRITE: `adr_src`=1, `mem_write`=1.
  - EXECUTER: `alu_src_a`=10, `alu_src_b`=00, alu_op funct.
  - EXECUTEI: `alu_src_a`=10, `alu_src_b`=01, alu_op funct.
  - ALUWB: `reg_write`=1.
  - BEQ: `alu_src_a`=10, `alu_src_b`=00, alu_op sub, branch=1.
  - JAL: `alu_src_a`=01, `alu_src_b`=10, add, pc_update=1.
- Branch resolution: `pc_write` = pc_update | (branch & (`zero` ^ `funct3`[0])). This covers beq (000) and bne (001).
- `imm_src` is combinational from `op`:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - otherwise → 00
- `alu_control` from alu_op (2-bit internal):
  - add → 000
  - sub → 001
  - funct, decoded on `funct3`:
    - 000: sub if `funct7b5` & `op`[5], else add
    - 010: slt
    - 110: or
    - 111: and
    - any other: 000
- `instr_done`=1 in MEMWB, MEMWRITE, ALUWB, BEQ, and in DECODE for an illegal opcode.

## Timing
- Reset:
  - While `reset`=1, all outputs are forced to 0 (no writes).
  - The cycle after `reset` falls, the FSM is in FETCH.
  - Reset asserted mid-instruction aborts the instruction; the next state is FETCH regardless of the current state.
- Cycles per instruction, FETCH to the next FETCH:
  - lw: 5
  - sw: 4
  - R-type, I-type, jal: 4
  - beq/bne: 3
  - illegal opcode: 2
- `op`, `funct3` and `funct7b5` are sampled only in DECODE and later. They must be stable from the cycle after FETCH until the instruction completes; the IR guarantees this.
- `zero` is used combinationally in BEQ only. It must be valid within the BEQ cycle.
- `pc_write` is asserted exactly once per instruction in FETCH; it is asserted a second time in JAL and in a taken branch.

## Structure
- Package `mc_pkg` holds:
  - state enum `mc_state_t` (FETCH…JAL)
  - alu_op enum (ADD, SUB, FUNCT)
  - named constants for every mux select encoding and opcode listed above.
- Sub-module `alu_decoder`: combinational; inputs alu_op, `funct3`, `funct7b5`, `op`[5]; output `alu_control`.
- The FSM is two-process: `always_ff` for the state register, `always_comb` for next-state logic and outputs.

## Test plan
- Reset behaviour: hold `reset`=1 for 3 cycles → all outputs 0. Release `reset` → next cycle is FETCH with `ir_write`=1, `pc_write`=1, `alu_src_b`=10, `result_src`=10.
- lw (`op`=0000011): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB → `mem_write` never 1, `reg_write`=1 only in cycle 5, `result_src`=01, `instr_done` pulses once.
- R-type sub (`op`=0110011, `funct3`=000, `funct7b5`=1) → `alu_control`=001 in EXECUTER. Same stimulus with `op`=0010011 (addi) → 000.
- Branches:
  - beq with `zero`=1 → `pc_write`=1 in BEQ.
  - beq with `zero`=0 → `pc_write`=0 in BEQ.
  - bne (`funct3`=001) with `zero`=0 → `pc_write`=1.
- jal (`op`=1101111) → `pc_write`=1 in both FETCH and JAL; `imm_src`=11; ALUWB has `reg_write`=1; 4 cycles total.
- Boundary cases:
  - Illegal `op`=1111111 → DECODE then FETCH with no write enables.
  - `reset` asserted during MEMREAD → next state FETCH; no `reg_write` occurs.
